// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: requester handshake, stall and the
// registered write-port outputs.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6
);
  logic                      stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_dest;
  logic [DATA_W-1:0]         wr_data;
  logic                      err_addr;
  logic                      busy;

  modport master (
    output stall, req_valid, req_dest, req_data,
    input  req_ready, wr_en, wr_dest, wr_data, err_addr, busy
  );

  modport slave (
    input  stall, req_valid, req_dest, req_data,
    output req_ready, wr_en, wr_dest, wr_data, err_addr, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ sources.
// Optional write-forwarding read ports are enabled with `define RFWA_FWD_EN.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 32
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
`ifdef RFWA_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      rd_addr_1,
  input  logic [ADDR_W-1:0]      rd_addr_2,
  output logic                   fwd_hit_1,
  output logic                   fwd_hit_2,
  output logic [DATA_W-1:0]      fwd_data_1,
  output logic [DATA_W-1:0]      fwd_data_2
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [PTR_W-1:0]   last_grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] ready_vec;
  logic [ADDR_W-1:0]  sel_dest;
  logic [DATA_W-1:0]  sel_data;
  logic               dest_zero;
  logic               dest_legal;

  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_dest_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               err_q;

  // Search starts just past the last granted requester and wraps around.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_p       = '0;
    if (!rst && !bus.stall) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx   = (32'(last_grant) + k) % NUM_REQ;
        idx_p = PTR_W'(idx);
        if (!grant_found && bus.req_valid[idx_p]) begin
          grant_found = 1'b1;
          grant_idx   = idx_p;
        end
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (grant_found) ready_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_dest = bus.req_dest[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign dest_zero  = (sel_dest == '0);
  assign dest_legal = ({1'b0, sel_dest} < REG_LIMIT);

  // r0 and out-of-range writes are still accepted, just never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
      wr_en_q    <= 1'b0;
      wr_dest_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= grant_found && !dest_zero && dest_legal;
      err_q   <= grant_found && !dest_legal;
      if (grant_found) begin
        last_grant <= grant_idx;
        wr_dest_q  <= sel_dest;
        wr_data_q  <= sel_data;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_dest   = wr_dest_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.err_addr  = err_q;
  assign bus.busy      = (|bus.req_valid) | wr_en_q;

`ifdef RFWA_FWD_EN
  assign fwd_hit_1  = wr_en_q && (wr_dest_q == rd_addr_1);
  assign fwd_hit_2  = wr_en_q && (wr_dest_q == rd_addr_2);
  assign fwd_data_1 = fwd_hit_1 ? wr_data_q : '0;
  assign fwd_data_2 = fwd_hit_2 ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a
// behavioural round-robin/write-port model, plus directed scenarios.
module tb_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef RFWA_FWD_EN
  logic [AW-1:0] rd_addr_1, rd_addr_2;
  logic          fwd_hit_1, fwd_hit_2;
  logic [DW-1:0] fwd_data_1, fwd_data_2;
`endif

  regfile_write_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREGS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RFWA_FWD_EN
    ,
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .fwd_hit_1(fwd_hit_1),
    .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1),
    .fwd_data_2(fwd_data_2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: round-robin pointer and the write-port register contents.
  int   m_last;
  logic m_wr_en;
  logic m_err;
  int   m_dest;
  int   m_data;
  int   last_gnt;

  logic [NR-1:0] seen_ready;
  logic          seen_en, seen_err;
  logic [AW-1:0] seen_dest;
  logic [DW-1:0] seen_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
    bus.req_valid[i]         = v;
    bus.req_dest[i*AW +: AW] = d;
    bus.req_data[i*DW +: DW] = x;
  endtask

  task automatic drop_granted();
    if (last_gnt >= 0) bus.req_valid[last_gnt] = 1'b0;
  endtask

  // Called at posedge+1; checks the cycle at negedge, then advances the model.
  task automatic step();
    int          g;
    int          d;
    logic [31:0] exp_r;
    g = -1;
    @(negedge clk);
    if (!bus.stall) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    end
    exp_r      = (g >= 0) ? (32'd1 << g) : 32'd0;
    seen_ready = bus.req_ready;
    seen_en    = bus.wr_en;
    seen_err   = bus.err_addr;
    seen_dest  = bus.wr_dest;
    seen_data  = bus.wr_data;
    check("req_ready", 32'(bus.req_ready), exp_r);
    check("busy", 32'(bus.busy), 32'((bus.req_valid != '0) || m_wr_en));
    check("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
    check("err_addr", 32'(bus.err_addr), 32'(m_err));
    check("wr_dest", 32'(bus.wr_dest), m_dest);
    check("wr_data", 32'(bus.wr_data), m_data);
`ifdef RFWA_FWD_EN
    begin
      int   r1, r2;
      logic h1, h2;
      r1 = 32'(rd_addr_1);
      r2 = 32'(rd_addr_2);
      h1 = m_wr_en && (m_dest == r1);
      h2 = m_wr_en && (m_dest == r2);
      check("fwd_hit_1", 32'(fwd_hit_1), 32'(h1));
      check("fwd_hit_2", 32'(fwd_hit_2), 32'(h2));
      check("fwd_data_1", 32'(fwd_data_1), h1 ? m_data : 0);
      check("fwd_data_2", 32'(fwd_data_2), h2 ? m_data : 0);
    end
`endif
    @(posedge clk);
    last_gnt = g;
    if (g >= 0) begin
      d       = 32'(bus.req_dest[g*AW +: AW]);
      m_dest  = d;
      m_data  = 32'(bus.req_data[g*DW +: DW]);
      m_wr_en = (d != 0) && (d < NREGS);
      m_err   = (d >= NREGS);
      m_last  = g;
    end else begin
      m_wr_en = 1'b0;
      m_err   = 1'b0;
    end
    #1;
  endtask

  // Async reset with all requesters valid: ready must stay low throughout.
  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.stall     = 1'b0;
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_err", 32'(bus.err_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    m_last   = NR - 1;
    m_wr_en  = 1'b0;
    m_err    = 1'b0;
    m_dest   = 0;
    m_data   = 0;
    last_gnt = -1;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst           = 1'b0;
  endtask

  initial begin
    bus.req_dest = '0;
    bus.req_data = '0;
`ifdef RFWA_FWD_EN
    rd_addr_1 = '0;
    rd_addr_2 = '0;
`endif
    do_reset();

    // Idle after reset
    for (int c = 0; c < 5; c++) step();

    // Single request
    set_req(0, 1'b1, 6'd5, 16'hA5A5);
    step();
    check("t2_ready", 32'(seen_ready), 32'd1);
    drop_granted();
    step();
    check("t2_en", 32'(seen_en), 32'd1);
    check("t2_dest", 32'(seen_dest), 32'd5);
    check("t2_data", 32'(seen_data), 32'hA5A5);
    step();
    check("t2_en_off", 32'(seen_en), 32'd0);

    // All three valid after reset: grants 0,1,2 and back-to-back writes r1..r3
    do_reset();
    set_req(0, 1'b1, 6'd1, 16'h0001);
    set_req(1, 1'b1, 6'd2, 16'h0002);
    set_req(2, 1'b1, 6'd3, 16'h0003);
    for (int c = 0; c < 6; c++) begin
      step();
      drop_granted();
      if (c < 3) check("t3_grant", 32'(seen_ready), 32'd1 << c);
      if (c >= 1 && c <= 3) begin
        check("t3_wr_en", 32'(seen_en), 32'd1);
        check("t3_wr_dest", 32'(seen_dest), 32'(c));
      end
    end

    // r0 write, then illegal address write, from requester 1
    set_req(1, 1'b1, 6'd0, 16'h0BAD);
    step();
    check("t4_ready_r0", 32'(seen_ready), 32'd2);
    drop_granted();
    set_req(1, 1'b1, 6'd40, 16'hDEAD);
    step();
    check("t4_ready_40", 32'(seen_ready), 32'd2);
    check("t4_r0_en", 32'(seen_en), 32'd0);
    check("t4_r0_err", 32'(seen_err), 32'd0);
    drop_granted();
    step();
    check("t4_40_en", 32'(seen_en), 32'd0);
    check("t4_40_err", 32'(seen_err), 32'd1);
    step();
    check("t4_err_clear", 32'(seen_err), 32'd0);

    // Put the pointer on 0, then stall with requesters 1 and 2 pending
    set_req(0, 1'b1, 6'd9, 16'h0909);
    step();
    drop_granted();
    set_req(1, 1'b1, 6'd10, 16'h1010);
    set_req(2, 1'b1, 6'd11, 16'h1111);
    bus.stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_stall_ready", 32'(seen_ready), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    check("t5_first", 32'(seen_ready), 32'd2);
    drop_granted();
    step();
    check("t5_second", 32'(seen_ready), 32'd4);
    drop_granted();
    step();

`ifdef RFWA_FWD_EN
    set_req(0, 1'b1, 6'd7, 16'h1234);
    step();
    drop_granted();
    rd_addr_1 = 6'd7;
    rd_addr_2 = 6'd8;
    step();
    check("t6_hit1", 32'(fwd_hit_1), 32'd1);
    check("t6_data1", 32'(fwd_data_1), 32'h1234);
    check("t6_hit2", 32'(fwd_hit_2), 32'd0);
    check("t6_data2", 32'(fwd_data_2), 32'd0);
`endif

    // Randomized traffic with stalls, r0/illegal destinations and one mid-run reset
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          int          sel;
          logic [AW-1:0] d;
          sel = int'($urandom_range(0, 19));
          if (sel < 2)      d = '0;
          else if (sel < 5) d = AW'($urandom_range(32, 63));
          else              d = AW'($urandom_range(1, 31));
          set_req(i, 1'b1, d, DW'($urandom));
        end
      end
      bus.stall = ($urandom_range(0, 4) == 0);
`ifdef RFWA_FWD_EN
      rd_addr_1 = ($urandom_range(0, 1) == 1) ? AW'(m_dest) : AW'($urandom_range(0, 63));
      rd_addr_2 = AW'($urandom_range(0, 63));
`endif
      step();
      drop_granted();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
